// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_RATIO_W   = 8;
    localparam int MIN_DIV_RATIO = 2;

endpackage

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider; ratio and enable changes land only on period boundaries.
// Optional one-cycle end-of-period tick output is built when CLK_DIV_TICK_EN is defined.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int RATIO_W     = DEF_RATIO_W,
    parameter int RESET_RATIO = 0
) (
    input  logic               ref_clk,
    input  logic               rst,
    input  logic               i_clk_en,
    input  logic [RATIO_W-1:0] i_ratio,
    input  logic               i_ratio_vld,
    output logic               o_ratio_rdy,
    output logic               o_div_clk,
    output logic               o_running,
    output logic               o_tick
);

    localparam logic [RATIO_W-1:0] RESET_RATIO_V = RATIO_W'(RESET_RATIO);
    localparam logic [RATIO_W-1:0] MIN_RATIO_V   = RATIO_W'(MIN_DIV_RATIO);
    localparam logic [RATIO_W-1:0] ONE_V         = RATIO_W'(1);

    state_e             state_q, state_d;
    logic [RATIO_W-1:0] act_ratio_q, act_ratio_d;
    logic [RATIO_W-1:0] pend_ratio_q, pend_ratio_d;
    logic               pend_vld_q, pend_vld_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic               div_q, div_d;

    logic               wrap;
    logic               boundary;
    logic               accept;
    logic [RATIO_W-1:0] eff_ratio;
    logic [RATIO_W-1:0] half_ratio;

    always_comb begin
        state_d      = state_q;
        act_ratio_d  = act_ratio_q;
        pend_ratio_d = pend_ratio_q;
        pend_vld_d   = pend_vld_q;
        cnt_d        = '0;
        div_d        = 1'b0;
        eff_ratio    = act_ratio_q;

        wrap     = (state_q == RUN) && (cnt_q == act_ratio_q - ONE_V);
        boundary = (state_q == IDLE) || wrap;
        accept   = i_ratio_vld && !pend_vld_q;

        // Accept and apply never coincide: accept needs pend_vld_q low, apply needs it high.
        if (accept) begin
            pend_ratio_d = i_ratio;
            pend_vld_d   = 1'b1;
        end

        if (boundary) begin
            if (pend_vld_q) begin
                act_ratio_d = pend_ratio_q;
                pend_vld_d  = 1'b0;
                eff_ratio   = pend_ratio_q;
            end
            state_d = (i_clk_en && (eff_ratio >= MIN_RATIO_V)) ? RUN : IDLE;
        end

        half_ratio = eff_ratio >> 1;

        if (state_d == RUN) begin
            cnt_d = (state_q == RUN && !wrap) ? cnt_q + ONE_V : '0;
            div_d = (cnt_d < half_ratio);
        end
    end

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            act_ratio_q  <= RESET_RATIO_V;
            pend_ratio_q <= '0;
            pend_vld_q   <= 1'b0;
            cnt_q        <= '0;
            div_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_ratio_q  <= act_ratio_d;
            pend_ratio_q <= pend_ratio_d;
            pend_vld_q   <= pend_vld_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
        end
    end

`ifdef CLK_DIV_TICK_EN
    logic tick_q, tick_d;

    // Registered so it is high exactly while cnt sits on the last phase of a RUN period.
    always_comb begin
        tick_d = (state_d == RUN) && (cnt_d == eff_ratio - ONE_V);
    end

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;
`else
    assign o_tick = 1'b0;
`endif

    // Select only flips on a boundary, where div_q is at a clean period edge.
    assign o_div_clk   = (state_q == RUN) ? div_q : ref_clk;
    assign o_running   = (state_q == RUN);
    assign o_ratio_rdy = !pend_vld_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: reset, exact periods, ratio handshake, enable and reset aborts.
module tb_clk_div_prog;

    localparam int RATIO_W = 8;

    logic               ref_clk = 1'b0;
    logic               rst;
    logic               i_clk_en;
    logic [RATIO_W-1:0] i_ratio;
    logic               i_ratio_vld;
    logic               o_ratio_rdy;
    logic               o_div_clk;
    logic               o_running;
    logic               o_tick;

    int checks   = 0;
    int failures = 0;

    always #5 ref_clk = ~ref_clk;

    clk_div_prog #(
        .RATIO_W     (RATIO_W),
        .RESET_RATIO (0)
    ) dut (
        .ref_clk     (ref_clk),
        .rst         (rst),
        .i_clk_en    (i_clk_en),
        .i_ratio     (i_ratio),
        .i_ratio_vld (i_ratio_vld),
        .o_ratio_rdy (o_ratio_rdy),
        .o_div_clk   (o_div_clk),
        .o_running   (o_running),
        .o_tick      (o_tick)
    );

    // Samples are taken 1 time unit after the posedge, so a bypassed output reads 1.
    task automatic step();
        @(posedge ref_clk);
        #1;
    endtask

    // Expected {running, rdy, div_clk, tick} for phase k of an n-cycle RUN period.
    function automatic logic [3:0] run_exp(int k, int n, logic rdy);
        logic div;
        logic tick;
        div  = ((k % n) < (n / 2));
`ifdef CLK_DIV_TICK_EN
        tick = ((k % n) == n - 1);
`else
        tick = 1'b0;
`endif
        return {1'b1, rdy, div, tick};
    endfunction

    function automatic logic [3:0] idle_exp(logic rdy);
        return {1'b0, rdy, 1'b1, 1'b0};
    endfunction

    function automatic logic [3:0] obs();
        return {o_running, o_ratio_rdy, o_div_clk, o_tick};
    endfunction

    task automatic go_idle();
        i_clk_en    = 1'b0;
        i_ratio_vld = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!o_running) break;
            step();
        end
        checks++;
        if (o_running !== 1'b0) begin
            failures++;
            $display("FAIL go_idle_timeout running=%b required=0", o_running);
        end
    endtask

    // Loads ratio r from IDLE with enable low, then enables; returns at phase k=0.
    task automatic start_run(int r);
        i_clk_en    = 1'b0;
        i_ratio     = RATIO_W'(r);
        i_ratio_vld = 1'b1;
        step();
        i_ratio_vld = 1'b0;
        checks++;
        if (o_ratio_rdy !== 1'b0) begin
            failures++;
            $display("FAIL load_pend ratio=%0d rdy=%b required=0", r, o_ratio_rdy);
        end
        step();
        checks++;
        if ({o_ratio_rdy, o_running} !== 2'b10) begin
            failures++;
            $display("FAIL load_apply ratio=%0d rdy_run=%b required=10", r, {o_ratio_rdy, o_running});
        end
        i_clk_en = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        i_clk_en    = 1'b1;
        i_ratio     = '0;
        i_ratio_vld = 1'b0;
        repeat (2) step();
        checks++;
        if (obs() !== idle_exp(1'b1)) begin
            failures++;
            $display("FAIL reset_hi got=%b required=%b", obs(), idle_exp(1'b1));
        end
        @(negedge ref_clk);
        #1;
        checks++;
        if (o_div_clk !== 1'b0) begin
            failures++;
            $display("FAIL reset_bypass_lo div=%b required=0", o_div_clk);
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (obs() !== idle_exp(1'b1)) begin
                failures++;
                $display("FAIL reset_ratio0_idle k=%0d got=%b required=%b", k, obs(), idle_exp(1'b1));
            end
        end
    endtask

    task automatic test_ratio(int n, int periods);
        go_idle();
        start_run(n);
        for (int k = 0; k < n * periods; k++) begin
            checks++;
            if (obs() !== run_exp(k, n, 1'b1)) begin
                failures++;
                $display("FAIL ratio_%0d k=%0d got=%b required=%b", n, k, obs(), run_exp(k, n, 1'b1));
            end
            step();
        end
    endtask

    task automatic test_mid_change();
        logic       rdy;
        logic [3:0] exp;
        go_idle();
        start_run(6);
        for (int k = 0; k < 16; k++) begin
            rdy = (k >= 3 && k < 6) ? 1'b0 : 1'b1;
            exp = (k < 6) ? run_exp(k, 6, rdy) : run_exp(k - 6, 3, rdy);
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL mid_change k=%0d got=%b required=%b", k, obs(), exp);
            end
            if (k == 2) begin
                i_ratio     = 8'd3;
                i_ratio_vld = 1'b1;
            end
            if (k == 3) i_ratio_vld = 1'b0;
            step();
        end
    endtask

    task automatic test_wrap_edge();
        logic       rdy;
        logic [3:0] exp;
        go_idle();
        start_run(6);
        for (int k = 0; k < 18; k++) begin
            rdy = (k >= 6 && k < 12) ? 1'b0 : 1'b1;
            exp = (k < 12) ? run_exp(k, 6, rdy) : run_exp(k - 12, 3, rdy);
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL wrap_edge k=%0d got=%b required=%b", k, obs(), exp);
            end
            if (k == 5) begin
                i_ratio     = 8'd3;
                i_ratio_vld = 1'b1;
            end
            if (k == 6) i_ratio = 8'd2;
            if (k == 8) i_ratio_vld = 1'b0;
            step();
        end
    endtask

    task automatic test_disable();
        logic [3:0] exp;
        go_idle();
        start_run(8);
        for (int k = 0; k < 11; k++) begin
            exp = (k < 8) ? run_exp(k, 8, 1'b1) : idle_exp(1'b1);
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL disable k=%0d got=%b required=%b", k, obs(), exp);
            end
            if (k == 0) i_clk_en = 1'b0;
            step();
        end
    endtask

    task automatic test_ratio_one();
        logic       rdy;
        logic [3:0] exp;
        go_idle();
        start_run(4);
        for (int k = 0; k < 8; k++) begin
            rdy = (k >= 2 && k < 4) ? 1'b0 : 1'b1;
            exp = (k < 4) ? run_exp(k, 4, rdy) : idle_exp(1'b1);
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL ratio_one k=%0d got=%b required=%b", k, obs(), exp);
            end
            if (k == 1) begin
                i_ratio     = 8'd1;
                i_ratio_vld = 1'b1;
            end
            if (k == 2) i_ratio_vld = 1'b0;
            step();
        end
    endtask

    task automatic test_reset_mid();
        go_idle();
        start_run(6);
        i_ratio     = 8'd3;
        i_ratio_vld = 1'b1;
        step();
        i_ratio_vld = 1'b0;
        checks++;
        if (obs() !== run_exp(1, 6, 1'b0)) begin
            failures++;
            $display("FAIL reset_mid_pre got=%b required=%b", obs(), run_exp(1, 6, 1'b0));
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== idle_exp(1'b1)) begin
            failures++;
            $display("FAIL reset_mid_async got=%b required=%b", obs(), idle_exp(1'b1));
        end
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (obs() !== idle_exp(1'b1)) begin
                failures++;
                $display("FAIL reset_mid_after k=%0d got=%b required=%b", k, obs(), idle_exp(1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ratio(4, 3);
        test_ratio(5, 3);
        test_ratio(255, 2);
        test_mid_change();
        test_wrap_edge();
        test_disable();
        test_ratio_one();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
